// File: rtl/dvp_pxl_dma.sv
// DVP pixel FIFO to memory AXI4 write-only burst master.
// Build option: DVP_DMA_ABORT_ON_ERR_EN ends the frame on a non-OKAY BRESP.
module dvp_pxl_dma #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int MST_ID_W         = 5,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_RESP_W     = 2,
    parameter int DMA_ID           = 0,
    parameter int BURST_LEN        = 16,
    parameter int FRAME_WORDS      = 38400,
    parameter int FIFO_LVL_W       = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 dvp_conf_i,
    input  logic [ADDR_W-1:0]           pxl_mem_base_i,
    input  logic [DATA_W-1:0]           fifo_data_i,
    input  logic [FIFO_LVL_W-1:0]       fifo_lvl_i,
    output logic                        fifo_rd_o,
    output logic [MST_ID_W-1:0]         m_awid_o,
    output logic [ADDR_W-1:0]           m_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
    output logic                        m_awvalid_o,
    input  logic                        m_awready_i,
    output logic [DATA_W-1:0]           m_wdata_o,
    output logic                        m_wlast_o,
    output logic                        m_wvalid_o,
    input  logic                        m_wready_i,
    input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
    input  logic                        m_bvalid_i,
    output logic                        m_bready_o,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        err_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int AL_W  = $clog2(BURST_LEN * BYTES);
    localparam int SH    = $clog2(BYTES);
    localparam int WC_W  = $clog2(FRAME_WORDS + 1);
    localparam int BL_W  = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {IDLE, WAIT, AW, W, B} state_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           addr_q, base_al;
    logic [WC_W-1:0]             word_cnt_q, word_nxt;
    logic [BL_W-1:0]             beats_q, beats_c, beat_cnt_q;
    logic [TRANS_DATA_LEN_W-1:0] awlen_q;
    logic [31:0]                 remain;
    logic en, cont, fifo_ok, aw_hs, w_hs, b_hs;
    logic last_beat, bad, frame_end, abort, start_ok, err_q;
    logic unused;

    assign en       = dvp_conf_i[0];
    assign cont     = dvp_conf_i[1];
    assign unused   = ^{dvp_conf_i[31:2], pxl_mem_base_i[AL_W-1:0]};
    // Burst-size alignment keeps every burst inside one 4 KB page.
    assign base_al  = {pxl_mem_base_i[ADDR_W-1:AL_W], {AL_W{1'b0}}};
    assign remain   = 32'(FRAME_WORDS) - 32'(word_cnt_q);
    assign beats_c  = (remain >= 32'(BURST_LEN)) ? BL_W'(BURST_LEN)
                                                 : BL_W'(remain);
    assign fifo_ok  = 32'(fifo_lvl_i) >= 32'(beats_c);
    assign aw_hs    = (state_q == AW) && m_awready_i;
    assign w_hs     = (state_q == W) && m_wready_i;
    assign b_hs     = (state_q == B) && m_bvalid_i;
    assign last_beat = beat_cnt_q == beats_q - BL_W'(1);
    assign bad      = m_bresp_i != '0;
    assign word_nxt = word_cnt_q + WC_W'(beats_q);
    assign frame_end = word_nxt == WC_W'(FRAME_WORDS);

`ifdef DVP_DMA_ABORT_ON_ERR_EN
    logic lock_q;

    assign abort    = b_hs && bad;
    assign start_ok = !lock_q;

    // Held after an aborted frame until enable is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      lock_q <= 1'b0;
        else if (abort)  lock_q <= 1'b1;
        else if (!en)    lock_q <= 1'b0;
    end
`else
    assign abort    = 1'b0;
    assign start_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en && start_ok) state_d = WAIT;
            WAIT: begin
                if (!en)          state_d = IDLE;
                else if (fifo_ok) state_d = AW;
            end
            AW:   if (m_awready_i) state_d = W;
            W:    if (m_wready_i && last_beat) state_d = B;
            B: begin
                if (m_bvalid_i) begin
                    if (abort)          state_d = IDLE;
                    else if (frame_end) state_d = (en && cont) ? WAIT : IDLE;
                    else                state_d = en ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            word_cnt_q <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            awlen_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && en && start_ok) begin
                addr_q     <= base_al;
                word_cnt_q <= '0;
                err_q      <= 1'b0;
            end
            if (state_q == WAIT && en && fifo_ok) begin
                beats_q <= beats_c;
                awlen_q <= TRANS_DATA_LEN_W'(beats_c - BL_W'(1));
            end
            if (aw_hs) beat_cnt_q <= '0;
            if (w_hs)  beat_cnt_q <= beat_cnt_q + BL_W'(1);
            if (b_hs) begin
                if (bad) err_q <= 1'b1;
                // Continuous mode picks up the base as it is now.
                if (frame_end && en && cont && !abort) begin
                    addr_q     <= base_al;
                    word_cnt_q <= '0;
                end else begin
                    word_cnt_q <= word_nxt;
                    addr_q     <= addr_q + (ADDR_W'(beats_q) << SH);
                end
            end
        end
    end

    assign m_awid_o     = MST_ID_W'(DMA_ID);
    assign m_awaddr_o   = addr_q;
    assign m_awlen_o    = awlen_q;
    assign m_awvalid_o  = state_q == AW;
    assign m_wvalid_o   = state_q == W;
    assign m_wdata_o    = m_wvalid_o ? fifo_data_i : '0;
    assign m_wlast_o    = m_wvalid_o && last_beat;
    assign fifo_rd_o    = m_wvalid_o && m_wready_i;
    assign m_bready_o   = state_q == B;
    assign busy_o       = state_q != IDLE;
    assign frame_done_o = b_hs && frame_end && !abort;
    assign err_o        = err_q;

endmodule

// File: tb/tb_dvp_pxl_dma.sv
// Bench for dvp_pxl_dma: queue FIFO, random-stall AXI slave,
// burst plan derived from frame size and burst length.
module tb_dvp_pxl_dma;

    localparam int FW = 40;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dvp_conf_i = '0;
    logic [31:0] pxl_mem_base_i = '0;
    logic [31:0] fifo_data_i = '0;
    logic [5:0]  fifo_lvl_i = '0;
    logic        fifo_rd_o;
    logic [4:0]  m_awid_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic        m_awvalid_o;
    logic        m_awready_i = 1'b0;
    logic [31:0] m_wdata_o;
    logic        m_wlast_o;
    logic        m_wvalid_o;
    logic        m_wready_i = 1'b0;
    logic [1:0]  m_bresp_i = '0;
    logic        m_bvalid_i = 1'b0;
    logic        m_bready_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        err_o;

    dvp_pxl_dma #(.FRAME_WORDS(FW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .dvp_conf_i(dvp_conf_i), .pxl_mem_base_i(pxl_mem_base_i),
        .fifo_data_i(fifo_data_i), .fifo_lvl_i(fifo_lvl_i),
        .fifo_rd_o(fifo_rd_o),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o),
        .m_awlen_o(m_awlen_o), .m_awvalid_o(m_awvalid_o),
        .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
        .m_bready_o(m_bready_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pixel FIFO model: every pushed word is also kept in hist.
    logic [31:0] fq[$];
    logic [31:0] hist[$];
    int push_total = 0;
    int pushed = 0;
    int underflow = 0;

    always @(posedge clk) begin
        logic [31:0] w;
        if (fifo_rd_o) begin
            if (fq.size() > 0) void'(fq.pop_front());
            else underflow++;
        end
        while (pushed < push_total) begin
            w = $urandom;
            fq.push_back(w);
            hist.push_back(w);
            pushed++;
        end
        fifo_lvl_i  <= 6'((fq.size() > 63) ? 63 : fq.size());
        fifo_data_i <= (fq.size() > 0) ? fq[0] : 32'h0;
    end

    // AXI slave with optional random stalls and error injection.
    bit rnd_en = 1'b0;
    int err_at = -1;
    int pend = 0;
    int b_given = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_wvalid_o && m_wready_i && m_wlast_o) pend++;
            if (m_bvalid_i && m_bready_o) begin
                pend--;
                b_given++;
            end
            m_awready_i <= !rnd_en || ($urandom_range(0, 3) != 0);
            m_wready_i  <= !rnd_en || ($urandom_range(0, 3) != 0);
            if (pend > 0 && (!rnd_en || $urandom_range(0, 2) != 0)) begin
                m_bvalid_i <= 1'b1;
                m_bresp_i  <= (b_given == err_at) ? 2'b10 : 2'b00;
            end else begin
                m_bvalid_i <= 1'b0;
                m_bresp_i  <= 2'b00;
            end
        end
    end

    // Passive recorder of bus traffic.
    logic [31:0] aw_addr[$];
    logic [7:0]  aw_len[$];
    logic [31:0] w_data[$];
    bit          w_last[$];
    bit in_burst = 1'b0;
    int gaps = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_burst && !m_wvalid_o) gaps++;
            if (m_awvalid_o && m_awready_i) begin
                aw_addr.push_back(m_awaddr_o);
                aw_len.push_back(m_awlen_o);
                in_burst = 1'b1;
            end
            if (m_wvalid_o && m_wready_i) begin
                w_data.push_back(m_wdata_o);
                w_last.push_back(m_wlast_o);
                if (m_wlast_o) in_burst = 1'b0;
            end
            if (frame_done_o) done_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_aw(input string tag, input int n, input int budget);
        int i = 0;
        while (aw_addr.size() < n && i < budget) begin
            step();
            i++;
        end
        chk(tag, 64'(aw_addr.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        step();
        step();
        while (busy_o && i < budget) begin
            step();
            i++;
        end
        chk(tag, 64'(busy_o), 0);
    endtask

    task automatic fill(input int need);
        int avail = push_total - w_data.size();
        if (need > avail) push_total += need - avail;
    endtask

    // Burst k of a frame: start word 16k, length min(16, words left).
    task automatic check_burst(input string tag, input int ai, input int wi,
                               input logic [31:0] base, input int k);
        int w = k * BL;
        int beats = (FW - w < BL) ? FW - w : BL;
        logic [31:0] ea = (base & ~32'h3F) + 32'(w * 4);
        chk($sformatf("%s_present", tag), 64'(aw_addr.size() > ai), 1);
        if (aw_addr.size() > ai) begin
            chk($sformatf("%s_awaddr", tag), aw_addr[ai], ea);
            chk($sformatf("%s_awlen", tag), aw_len[ai], 64'(beats - 1));
        end
        for (int b = 0; b < beats; b++) begin
            if (wi + b < w_data.size()) begin
                chk($sformatf("%s_wdata%0d", tag, b), w_data[wi + b],
                    hist[wi + b]);
                chk($sformatf("%s_wlast%0d", tag, b), 64'(w_last[wi + b]),
                    64'(b == beats - 1));
            end else begin
                chk($sformatf("%s_beat%0d", tag, b), 0, 1);
            end
        end
    endtask

    int aw0, w0, d0;

    initial begin
        repeat (3) step();
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_awvalid", 64'(m_awvalid_o), 0);
        chk("rst_wvalid", 64'(m_wvalid_o), 0);
        chk("rst_bready", 64'(m_bready_o), 0);
        chk("rst_fifo_rd", 64'(fifo_rd_o), 0);
        chk("rst_done", 64'(frame_done_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_awaddr", m_awaddr_o, 0);
        chk("rst_awlen", m_awlen_o, 0);
        chk("rst_awid", m_awid_o, 0);
        rst_n = 1'b1;
        step();

        // One-shot frame with random stalls: 16 + 16 + 8 beats.
        rnd_en = 1'b1;
        fill(FW);
        repeat (2) step();
        aw0 = aw_addr.size(); w0 = w_data.size(); d0 = done_cnt;
        pxl_mem_base_i = 32'h8000_0000;
        dvp_conf_i = 32'h1;
        wait_aw("p1_wait_aw", aw0 + 3, 3000);
        dvp_conf_i = 32'h0;
        wait_idle("p1_idle", 1000);
        chk("p1_aw_cnt", aw_addr.size() - aw0, 3);
        check_burst("p1_b0", aw0, w0, 32'h8000_0000, 0);
        check_burst("p1_b1", aw0 + 1, w0 + 16, 32'h8000_0000, 1);
        check_burst("p1_b2", aw0 + 2, w0 + 32, 32'h8000_0000, 2);
        chk("p1_beats", w_data.size() - w0, FW);
        chk("p1_done", done_cnt - d0, 1);
        chk("p1_err", 64'(err_o), 0);

        // Level gating, then enable dropped in burst 2's W phase.
        rnd_en = 1'b0;
        fill(10);
        repeat (2) step();
        aw0 = aw_addr.size(); w0 = w_data.size(); d0 = done_cnt;
        pxl_mem_base_i = 32'h8000_0013;
        dvp_conf_i = 32'h1;
        repeat (6) step();
        chk("p2_lvl10_awvalid", 64'(m_awvalid_o), 0);
        chk("p2_lvl10_busy", 64'(busy_o), 1);
        push_total += 6;
        step();
        step();
        chk("p2_lvl16_awvalid", 64'(m_awvalid_o), 1);
        push_total += 24;
        wait_aw("p2_wait_aw2", aw0 + 2, 500);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (m_wvalid_o) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            chk("p2_w2_seen", 64'(ok), 1);
        end
        dvp_conf_i = 32'h0;
        wait_idle("p2_idle", 500);
        repeat (20) step();
        chk("p2_aw_cnt", aw_addr.size() - aw0, 2);
        chk("p2_beats", w_data.size() - w0, 32);
        chk("p2_done", done_cnt - d0, 0);
        chk("p2_busy_late", 64'(busy_o), 0);
        check_burst("p2_b0", aw0, w0, 32'h8000_0013, 0);
        check_burst("p2_b1", aw0 + 1, w0 + 16, 32'h8000_0013, 1);

        // Continuous mode, base rewritten mid-frame.
        rnd_en = 1'b1;
        fill(2 * FW);
        repeat (2) step();
        aw0 = aw_addr.size(); w0 = w_data.size(); d0 = done_cnt;
        pxl_mem_base_i = 32'h8000_0000;
        dvp_conf_i = 32'h3;
        wait_aw("p3_wait_aw2", aw0 + 2, 3000);
        pxl_mem_base_i = 32'h9000_0000;
        wait_aw("p3_wait_aw4", aw0 + 4, 3000);
        dvp_conf_i = 32'h0;
        wait_idle("p3_idle", 1000);
        chk("p3_aw_cnt", aw_addr.size() - aw0, 4);
        check_burst("p3_b0", aw0, w0, 32'h8000_0000, 0);
        check_burst("p3_b1", aw0 + 1, w0 + 16, 32'h8000_0000, 1);
        check_burst("p3_b2", aw0 + 2, w0 + 32, 32'h8000_0000, 2);
        check_burst("p3_f2b0", aw0 + 3, w0 + 40, 32'h9000_0000, 0);
        chk("p3_done", done_cnt - d0, 1);

        // SLVERR on the first burst of a frame.
        fill(FW);
        repeat (2) step();
        aw0 = aw_addr.size(); w0 = w_data.size(); d0 = done_cnt;
        err_at = b_given;
        pxl_mem_base_i = 32'h8000_0000;
        dvp_conf_i = 32'h1;
`ifdef DVP_DMA_ABORT_ON_ERR_EN
        wait_idle("p4_idle", 1000);
        repeat (20) step();
        chk("p4_aw_cnt", aw_addr.size() - aw0, 1);
        chk("p4_busy", 64'(busy_o), 0);
        chk("p4_err", 64'(err_o), 1);
        chk("p4_done", done_cnt - d0, 0);
        check_burst("p4_b0", aw0, w0, 32'h8000_0000, 0);
        err_at = -1;
        dvp_conf_i = 32'h0;
        step();
        dvp_conf_i = 32'h1;
        step();
        step();
        chk("p4_rearm_busy", 64'(busy_o), 1);
        chk("p4_rearm_err", 64'(err_o), 0);
        dvp_conf_i = 32'h0;
        wait_idle("p4_idle2", 1000);
`else
        wait_aw("p4_wait_aw3", aw0 + 3, 3000);
        dvp_conf_i = 32'h0;
        wait_idle("p4_idle", 1000);
        chk("p4_aw_cnt", aw_addr.size() - aw0, 3);
        chk("p4_err", 64'(err_o), 1);
        chk("p4_done", done_cnt - d0, 1);
        check_burst("p4_b0", aw0, w0, 32'h8000_0000, 0);
        check_burst("p4_b1", aw0 + 1, w0 + 16, 32'h8000_0000, 1);
        check_burst("p4_b2", aw0 + 2, w0 + 32, 32'h8000_0000, 2);
        err_at = -1;
`endif

        chk("fifo_underflow", underflow, 0);
        chk("wvalid_gaps", gaps, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dvp_pxl_dma.md
Name: dvp_pxl_dma

Overview:
- AXI4 write-only master that moves captured pixel words from the DVP RX pixel FIFO into system memory.
- Sequences one frame as a series of INCR bursts, starting at the pixel memory base address held in the config block.
- Driven by the DVP control/status register (enable, continuous) and the pixel memory base register.
- Reports frame completion and bus errors back to the status logic.

Parameters:
- DATA_W, 32, AXI data width and pixel FIFO word width.
- ADDR_W, 32, AXI address width.
- MST_ID_W, 5, AXI ID width.
- TRANS_DATA_LEN_W, 8, AXI AxLEN width.
- TRANS_RESP_W, 2, AXI BRESP width.
- DMA_ID, 0, constant AWID driven on every burst.
- BURST_LEN, 16, maximum beats per burst (power of 2, ≤ 256).
- FRAME_WORDS, 38400, DATA_W words per frame (320x240 RGB565).
- FIFO_LVL_W, 6, width of the FIFO fill-level input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dvp_conf_i  in  32  bit0 = enable, bit1 = continuous; other bits ignored
- pxl_mem_base_i  in  ADDR_W  frame base byte address; low log2(BURST_LEN*DATA_W/8) bits forced to 0
- fifo_data_i  in  DATA_W  show-ahead head word of the pixel FIFO
- fifo_lvl_i  in  FIFO_LVL_W  words currently stored in the FIFO
- fifo_rd_o  out  1  pop strobe
- m_awid_o  out  MST_ID_W  AWID
- m_awaddr_o  out  ADDR_W  AWADDR
- m_awlen_o  out  TRANS_DATA_LEN_W  AWLEN
- m_awvalid_o  out  1  AWVALID
- m_awready_i  in  1  AWREADY
- m_wdata_o  out  DATA_W  WDATA
- m_wlast_o  out  1  WLAST
- m_wvalid_o  out  1  WVALID
- m_wready_i  in  1  WREADY
- m_bresp_i  in  TRANS_RESP_W  BRESP
- m_bvalid_i  in  1  BVALID
- m_bready_o  out  1  BREADY
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse on final B of a frame
- err_o  out  1  sticky: any non-OKAY BRESP

Behaviour:
- Reset state: FSM = IDLE, counters = 0, all outputs = 0. AWID is constant DMA_ID.
- FSM states: IDLE, WAIT, AW, W, B.
- IDLE:
  - When enable = 1: latch the aligned base into addr_q, clear word_cnt, clear err_o, go to WAIT.
  - busy_o = 1 in every state except IDLE.
- WAIT:
  - beats = min(BURST_LEN, FRAME_WORDS - word_cnt).
  - Go to AW when fifo_lvl_i ≥ beats. This rule guarantees WVALID never deasserts mid-burst.
- AW:
  - Drive m_awvalid_o = 1, m_awaddr_o = addr_q, m_awlen_o = beats - 1.
  - Address and length are registered and stay stable until AWREADY.
  - On AWVALID & AWREADY go to W and clear beat_cnt.
- W:
  - m_wvalid_o = 1 and m_wdata_o = fifo_data_i.
  - fifo_rd_o = m_wvalid_o & m_wready_i, so exactly one pop per accepted beat.
  - m_wlast_o = (beat_cnt == beats - 1).
  - On the last accepted beat go to B.
- B:
  - m_bready_o = 1.
  - On BVALID:
    - If BRESP != 0, set err_o.
    - word_cnt += beats; addr_q += beats*DATA_W/8.
  - If the frame is complete (word_cnt reaches FRAME_WORDS):
    - Pulse frame_done_o.
    - If enable & continuous: re-latch base, word_cnt = 0, go to WAIT.
    - Otherwise go to IDLE.
  - If the frame is not complete: go to WAIT when enable = 1; go to IDLE when enable = 0.
- Disabling:
  - enable dropped mid-burst never abandons an AXI transaction.
  - The current burst completes through B, then the FSM returns to IDLE.
- Config changes:
  - A base change during a frame takes effect only at the next frame start.
- Single-outstanding transaction; AW always precedes W.
- Bursts never cross 4 KB because the base is aligned to the burst size.
- Last burst of a frame may be short (FRAME_WORDS mod BURST_LEN).
- Reset asserted mid-burst returns immediately to the reset state. The interconnect is reset with the same rst_n.

Optional Feature:
- Macro: DVP_DMA_ABORT_ON_ERR_EN.
- Defined:
  - A non-OKAY BRESP sets err_o, ends the frame with no frame_done_o pulse, and forces IDLE regardless of the continuous bit.
  - A new frame starts only when enable is cleared and then set again.
- Undefined:
  - Errors only set err_o; the frame continues and completes normally.

Test Plan:
- FRAME_WORDS = 40, BURST_LEN = 16, base 0x8000_0000, enable = 1, continuous = 0, FIFO pre-filled → three bursts (AWADDR/AWLEN: 0x8000_0000/15, 0x8000_0040/15, 0x8000_0080/7); 40 pops; frame_done_o once; then IDLE with busy_o = 0.
- fifo_lvl_i held at 10 with first burst pending → no AWVALID. Raise to 16 → AWVALID next cycle.
- Random WREADY/AWREADY/BVALID stalls → WDATA equals the FIFO order; WVALID never drops mid-burst; WLAST only on the final beat.
- continuous = 1, base rewritten to 0x9000_0000 mid-frame → current frame stays at 0x8000_xxxx; the next frame's first AWADDR is 0x9000_0000.
- enable cleared during second-burst W phase → second burst completes with its B; no third AW; busy_o = 0.
- BRESP = 2'b10 on burst 1:
  - Macro undefined: err_o = 1 and frame_done_o still fires.
  - Macro defined: IDLE after that B, no further AW, no frame_done_o.
